// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer.
// Optional macro SERIAL_ADD_OVF_EN (used by the interface and top) adds a signed-overflow output.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  localparam int SA_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake and result bus of the serial adder.
// SERIAL_ADD_OVF_EN adds the ovf result bit.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, s, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, s, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, s, cout);
  modport slave  (input start, a, b, cin, output busy, done, s, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl_fulladder.sv
// Existing 1-bit full-adder cell, shared by every bit position of the serial adder.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full adder, one bit per clock, LSB first.
// Define SERIAL_ADD_OVF_EN to also register two's-complement overflow (ovf).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  sa_state_t          r_state;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-2:0]   r_acc;
  logic [WIDTH-1:0]   r_s;
  logic               r_cout;
  logic               r_busy;
  logic               r_done;

  logic               w_fa_s;
  logic               w_fa_cout;
  logic [WIDTH-1:0]   w_acc_cat;
  logic               w_last;

  fulladder u_fa (
    .a    (r_op_a[0]),
    .b    (r_op_b[0]),
    .cin  (r_carry),
    .s    (w_fa_s),
    .cout (w_fa_cout)
  );

  // The accumulator holds only WIDTH-1 bits; the final sum bit comes straight from the adder.
  assign w_acc_cat = {w_fa_s, r_acc};
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;
  assign bus.ovf = r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op_a  <= bus.a;
            r_op_b  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc   <= w_acc_cat[WIDTH-1:1];
          r_carry <= w_fa_cout;
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_s     <= w_acc_cat;
            r_cout  <= w_fa_cout;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
`ifdef SERIAL_ADD_OVF_EN
            // r_carry is still the carry into the MSB at this edge
            r_ovf   <= r_carry ^ w_fa_cout;
`endif
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.s    = r_s;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: stimulus pushes expected results, a monitor pops on done.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_add_ctrl_if #(.WIDTH(W)) ifc ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  exp_t         sb_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  int           n_done = 0;
  logic [W-1:0] prev_s = '0;
  logic         prev_cout = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && ifc.done === 1'b1) begin
      exp_t e;
      n_done++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_s", 32'(ifc.s), 32'(e.s));
        check("sb_cout", 32'(ifc.cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
        check("sb_ovf", 32'(ifc.ovf), 32'(e.ovf));
`endif
      end
    end
  end

  function automatic logic ovf_of(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // One full transaction; disturb pulses start and changes a/b mid-SHIFT.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ecout, input bit disturb);
    exp_t e;
    e.s = es; e.cout = ecout; e.ovf = ovf_of(a, b, es);
    @(negedge clk);
    ifc.start = 1'b1; ifc.a = a; ifc.b = b; ifc.cin = cin;
    sb_q.push_back(e);
    @(negedge clk);
    ifc.start = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (k > 0) @(negedge clk);
      check("busy_shift", 32'(ifc.busy), 32'd1);
      check("no_done_shift", 32'(ifc.done), 32'd0);
      check("s_held", 32'(ifc.s), 32'(prev_s));
      check("cout_held", 32'(ifc.cout), 32'(prev_cout));
      if (disturb && k == 1) begin
        ifc.start = 1'b1; ifc.a = 4'd1; ifc.b = 4'd1; ifc.cin = 1'b1;
      end
      if (disturb && k == 2) ifc.start = 1'b0;
    end
    @(negedge clk);
    check("done_pulse", 32'(ifc.done), 32'd1);
    check("busy_in_done", 32'(ifc.busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(ifc.done), 32'd0);
    prev_s = es; prev_cout = ecout;
  endtask

  initial begin
    int done_before;
    int cyc;
    int done_cyc[$];
    exp_t e;

    ifc.start = 1'b0; ifc.a = '0; ifc.b = '0; ifc.cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_s", 32'(ifc.s), 32'd0);
    check("rst_cout", 32'(ifc.cout), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);

    run_op(4'd6,  4'd3,  1'b0, 4'b1001, 1'b0, 1'b0);
    run_op(4'd12, 4'd5,  1'b1, 4'b0010, 1'b1, 1'b0);
    run_op(4'd15, 4'd15, 1'b1, 4'b1111, 1'b1, 1'b0);
    run_op(4'd0,  4'd0,  1'b0, 4'b0000, 1'b0, 1'b0);

    done_before = n_done;
    run_op(4'd2, 4'd5, 1'b0, 4'd7, 1'b0, 1'b1);
    repeat (W + 3) @(negedge clk);
    check("ignored_start_one_done", 32'(n_done - done_before), 32'd1);

    // Abort in the middle of SHIFT: nothing is expected from this operation.
    done_before = n_done;
    ifc.start = 1'b1; ifc.a = 4'd5; ifc.b = 4'd5; ifc.cin = 1'b0;
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_s", 32'(ifc.s), 32'd0);
    check("abort_cout", 32'(ifc.cout), 32'd0);
    check("abort_busy", 32'(ifc.busy), 32'd0);
    check("abort_done", 32'(ifc.done), 32'd0);
    rst = 1'b0;
    prev_s = '0; prev_cout = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("abort_no_done", 32'(n_done - done_before), 32'd0);
    run_op(4'd3, 4'd4, 1'b0, 4'd7, 1'b0, 1'b0);

    // Back-to-back with start held high.
    e.s = 4'd9; e.cout = 1'b0; e.ovf = 1'b1;
    repeat (3) sb_q.push_back(e);
    @(negedge clk);
    ifc.start = 1'b1; ifc.a = 4'd6; ifc.b = 4'd3; ifc.cin = 1'b0;
    cyc = 0;
    while (done_cyc.size() < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ifc.done === 1'b1) done_cyc.push_back(cyc);
    end
    ifc.start = 1'b0;
    check("b2b_three_dones", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() == 3) begin
      check("b2b_first_latency", 32'(done_cyc[0]), 32'(W + 1));
      check("b2b_period_1", 32'(done_cyc[1] - done_cyc[0]), 32'(W + 2));
      check("b2b_period_2", 32'(done_cyc[2] - done_cyc[1]), 32'(W + 2));
    end
    repeat (W + 4) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
